// File: rtl/rc_accum_readout_if.sv
// Stream bundle for the RC accumulator readout stage: the vector-wide input
// stream from the accumulate stage and the per-element output stream.
interface rc_accum_readout_if #(
  parameter int NO = 4,
  parameter int WA = 12,
  parameter int WO = 8,
  parameter int IW = (NO > 1) ? $clog2(NO) : 1
);
  // Input vector stream (accumulate stage -> readout)
  logic             iValid_AS_RcAccum;
  logic             oReady_AS_RcAccum;
  logic [NO*WA-1:0] iData_AS_RcAccum;

  // Output element stream (readout -> consumer)
  logic             oValid_BM_Readout;
  logic             iReady_BM_Readout;
  logic [WO-1:0]    oData_BM_Readout;
  logic [IW-1:0]    oIdx_BM_Readout;
  logic             oLast_BM_Readout;
  logic             oSat_BM_Readout;

  // Readout stage side
  modport slave (
    input  iValid_AS_RcAccum,
    input  iData_AS_RcAccum,
    input  iReady_BM_Readout,
    output oReady_AS_RcAccum,
    output oValid_BM_Readout,
    output oData_BM_Readout,
    output oIdx_BM_Readout,
    output oLast_BM_Readout,
    output oSat_BM_Readout
  );

  // Producer / consumer side
  modport master (
    output iValid_AS_RcAccum,
    output iData_AS_RcAccum,
    output iReady_BM_Readout,
    input  oReady_AS_RcAccum,
    input  oValid_BM_Readout,
    input  oData_BM_Readout,
    input  oIdx_BM_Readout,
    input  oLast_BM_Readout,
    input  oSat_BM_Readout
  );
endinterface

// File: rtl/rc_accum_readout.sv
// Readout stage for the reservoir differential MAC path. Captures one vector
// of NO signed accumulator sums, then streams the elements one per beat after
// round-half-up, arithmetic right shift by SHIFT and saturation to WO bits.
// A new vector may be taken on the last-beat handshake, so back-to-back
// vectors stream without a bubble. WA is assumed to be at least WO.
module rc_accum_readout #(
  parameter int NH    = 32,
  parameter int NO    = 4,
  parameter int WS    = 8,
  parameter int WO    = 8,
  parameter int SHIFT = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  rc_accum_readout_if.slave bus
);

  localparam int WA = $clog2(NH) + WS;
  localparam int IW = (NO > 1) ? $clog2(NO) : 1;

  localparam logic [IW-1:0]      IDX_LAST = IW'(NO - 1);
  // Rounding constant 2^(SHIFT-1); evaluates to 0 when SHIFT is 0.
  localparam logic signed [WA:0] RND      = (WA+1)'((2 ** SHIFT) / 2);
  localparam logic signed [WA:0] SAT_MAX  = (WA+1)'((2 ** (WO - 1)) - 1);
  localparam logic signed [WA:0] SAT_MIN  = (WA+1)'(-(2 ** (WO - 1)));

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NO*WA-1:0]       hold_q;
  logic [WO-1:0]          data_q;
  logic                   sat_q;
  logic                   last_q;
  logic                   last_d;
  logic                   run_q;
  logic                   load;
  logic signed [WA-1:0]   elem;
  logic [WO:0]            conv;
  logic                   in_hs;
  logic                   out_hs;
  logic                   ready_as;

  // Scale one accumulator sum: {sat, value}. The extra MSB keeps the
  // rounding add of the largest positive sum from wrapping negative.
  function automatic logic [WO:0] convert(input logic signed [WA-1:0] x);
    logic signed [WA:0] t;
    logic [WO:0]        r;
    t = ($signed({x[WA-1], x}) + RND) >>> SHIFT;
    if (t > SAT_MAX) begin
      r = {1'b1, SAT_MAX[WO-1:0]};
    end else if (t < SAT_MIN) begin
      r = {1'b1, SAT_MIN[WO-1:0]};
    end else begin
      r = {1'b0, t[WO-1:0]};
    end
    return r;
  endfunction

  // Handshakes; input ready is combinational from the consumer's ready so a
  // new vector can land on the final beat of the current one.
  always_comb begin
    out_hs   = (state_q == EMIT) & bus.iReady_BM_Readout;
    ready_as = run_q & ((state_q == IDLE) | (out_hs & last_q));
    in_hs    = bus.iValid_AS_RcAccum & ready_as;
  end

  // Next state, next index and which element feeds the converter.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    elem    = '0;
    if (in_hs) begin
      state_d = EMIT;
      idx_d   = '0;
      load    = 1'b1;
      elem    = bus.iData_AS_RcAccum[WA-1:0];
    end else if (out_hs) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
        load  = 1'b1;
        elem  = hold_q[int'(idx_d) * WA +: WA];
      end
    end
    conv   = convert(elem);
    last_d = (idx_d == IDX_LAST);
  end

  // State, index and registered output element.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        data_q <= conv[WO-1:0];
        sat_q  <= conv[WO];
        last_q <= last_d;
      end
    end
  end

  // Input ready stays low while in reset and rises on the first clock after.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Vector holding register, written only on an accepted input vector.
  always_ff @(posedge iCLK) begin
    // NOTE: the holding register carries no reset; it is always written
    // before any element of it is read, so reset would only add wiring.
    if (in_hs) begin
      hold_q <= bus.iData_AS_RcAccum;
    end
  end

  // Output drive.
  always_comb begin
    bus.oReady_AS_RcAccum = ready_as;
    bus.oValid_BM_Readout = (state_q == EMIT);
    bus.oData_BM_Readout  = data_q;
    bus.oIdx_BM_Readout   = idx_q;
    bus.oLast_BM_Readout  = last_q;
    bus.oSat_BM_Readout   = sat_q;
  end

endmodule
